// File: rtl/wtb_pkg.sv
// Shared types and constants for the word_to_byte_tx UART transmitter.
// WTB_PARITY_EN adds an even-parity bit state to the serializer.
package wtb_pkg;

   localparam int unsigned FRAME_DATA_BITS = 8;
   localparam int unsigned WORD_BYTES      = 4;
   localparam logic        IDLE_LEVEL      = 1'b1;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
`ifdef WTB_PARITY_EN
      TX_PARITY,
`endif
      TX_STOP
   } tx_state_e;

   typedef enum logic [1:0] {
      CTL_IDLE,
      CTL_SEND,
      CTL_DONE
   } ctl_state_e;

   function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
      return w[{idx, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART byte serializer: start bit, 8 data bits LSB first, optional even parity
// (WTB_PARITY_EN), stop bit. A start request seen in the last stop cycle chains frames with no gap.
module uart_tx_byte
   import wtb_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic [7:0] data_i,
   output logic       serial_o,
   output logic       busy_o,
   output logic       last_o
);

   localparam int unsigned     CW      = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]   CNT_MAX = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]      BIT_MAX = 3'(FRAME_DATA_BITS - 1);

   tx_state_e     state_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    bit_q;
   logic [7:0]    data_q;
   logic          serial_q;
   logic          bit_end;

   assign bit_end  = (cnt_q == CNT_MAX);
   assign serial_o = serial_q;
   assign busy_o   = (state_q != TX_IDLE);
   assign last_o   = (state_q == TX_STOP) && bit_end;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= TX_IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         data_q   <= '0;
         serial_q <= IDLE_LEVEL;
      end else begin
         if (state_q != TX_IDLE) cnt_q <= bit_end ? '0 : cnt_q + CW'(1);
         case (state_q)
            TX_IDLE: begin
               if (start_i) begin
                  state_q  <= TX_START;
                  data_q   <= data_i;
                  cnt_q    <= '0;
                  serial_q <= 1'b0;
               end
            end
            TX_START: begin
               if (bit_end) begin
                  state_q  <= TX_DATA;
                  bit_q    <= '0;
                  serial_q <= data_q[0];
               end
            end
            TX_DATA: begin
               if (bit_end) begin
                  if (bit_q == BIT_MAX) begin
`ifdef WTB_PARITY_EN
                     state_q  <= TX_PARITY;
                     serial_q <= ^data_q;
`else
                     state_q  <= TX_STOP;
                     serial_q <= 1'b1;
`endif
                  end else begin
                     bit_q    <= bit_q + 3'd1;
                     serial_q <= data_q[bit_q + 3'd1];
                  end
               end
            end
`ifdef WTB_PARITY_EN
            TX_PARITY: begin
               if (bit_end) begin
                  state_q  <= TX_STOP;
                  serial_q <= 1'b1;
               end
            end
`endif
            TX_STOP: begin
               if (bit_end) begin
                  if (start_i) begin
                     state_q  <= TX_START;
                     data_q   <= data_i;
                     serial_q <= 1'b0;
                  end else begin
                     state_q  <= TX_IDLE;
                  end
               end
            end
            default: state_q <= TX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/word_to_byte_tx.sv
// UART TX front-end: one byte, or a 32-bit word as four back-to-back bytes, repeated while enable is high.
// Define WTB_PARITY_EN for an even-parity bit per byte.
module word_to_byte_tx
   import wtb_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic        i_mode_select,
   input  logic [31:0] i_word,
   input  logic [7:0]  i_byte,
   output logic        o_serial,
   output logic        o_done
);

   ctl_state_e  ctl_q;
   logic        mode_q;
   logic [31:0] word_q;
   logic [1:0]  idx_q;
   logic        done_q;

   logic        tx_start_d;
   logic [7:0]  tx_data_d;
   logic        tx_busy;
   logic        tx_last;

   // In IDLE the serializer is fed straight from the inputs so the start bit leaves on the latching edge.
   always_comb begin
      tx_start_d = 1'b0;
      tx_data_d  = i_byte;
      case (ctl_q)
         CTL_IDLE: begin
            tx_start_d = enable && !tx_busy;
            tx_data_d  = i_mode_select ? i_word[7:0] : i_byte;
         end
         CTL_SEND: begin
            tx_start_d = tx_last && mode_q && (idx_q != 2'(WORD_BYTES - 1));
            tx_data_d  = byte_sel(word_q, idx_q + 2'd1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ctl_q  <= CTL_IDLE;
         mode_q <= 1'b0;
         word_q <= '0;
         idx_q  <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (ctl_q)
            CTL_IDLE: begin
               if (tx_start_d) begin
                  ctl_q  <= CTL_SEND;
                  mode_q <= i_mode_select;
                  word_q <= i_word;
                  idx_q  <= '0;
               end
            end
            CTL_SEND: begin
               if (tx_last) begin
                  if (tx_start_d) begin
                     idx_q <= idx_q + 2'd1;
                  end else begin
                     ctl_q  <= CTL_DONE;
                     done_q <= 1'b1;
                  end
               end
            end
            CTL_DONE: ctl_q <= CTL_IDLE;
            default:  ctl_q <= CTL_IDLE;
         endcase
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_ser (
      .clk_i   (clock),
      .rst_i   (reset),
      .start_i (tx_start_d),
      .data_i  (tx_data_d),
      .serial_o(o_serial),
      .busy_o  (tx_busy),
      .last_o  (tx_last)
   );

   assign o_done = done_q;

endmodule

// File: tb/tb_word_to_byte_tx.sv
// Self-checking bench for word_to_byte_tx: frame decoder with expected-byte scoreboard,
// table-driven transfers, and directed sequences for enable/input changes and reset.
module tb_word_to_byte_tx;

   localparam int CPB = 4;
`ifdef WTB_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME_CYC = NB * CPB;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable;
   logic        i_mode_select;
   logic [31:0] i_word;
   logic [7:0]  i_byte;
   logic        o_serial;
   logic        o_done;

   int total = 0;
   int bad   = 0;

   logic [7:0] sb[$];
   int         done_cnt  = 0;
   int         start_cnt = 0;
   time        start_t   = 0;

   word_to_byte_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clock        (clock),
      .reset        (reset),
      .enable       (enable),
      .i_mode_select(i_mode_select),
      .i_word       (i_word),
      .i_byte       (i_byte),
      .o_serial     (o_serial),
      .o_done       (o_done)
   );

   always #5 clock = ~clock;

   always @(negedge clock) if (o_done === 1'b1) done_cnt <= done_cnt + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // Frame decoder: every cycle of each bit must hold the same level.
   logic [NB-1:0] mon_bits;
   bit            mon_glitch, mon_abort;
   initial begin : monitor
      forever begin
         @(negedge clock);
         if (reset === 1'b0 && o_serial === 1'b0) begin
            start_t    = $time;
            start_cnt++;
            mon_glitch = 0;
            mon_abort  = 0;
            for (int k = 0; k < NB; k++) begin
               for (int c = 0; c < CPB; c++) begin
                  if (!(k == 0 && c == 0)) @(negedge clock);
                  if (reset !== 1'b0) mon_abort = 1;
                  if (c == 0) mon_bits[k] = o_serial;
                  else if (o_serial !== mon_bits[k]) mon_glitch = 1;
               end
               if (mon_abort) break;
            end
            if (!mon_abort) begin
               if (sb.size() == 0) begin
                  chk("unexpected_frame", {22'd0, mon_bits}, 32'd0);
               end else begin
                  logic [7:0] e;
                  logic       ok;
                  e  = sb.pop_front();
                  ok = !mon_glitch && mon_bits[0] == 1'b0 && mon_bits[NB-1] == 1'b1
                       && mon_bits[8:1] == e;
`ifdef WTB_PARITY_EN
                  ok = ok && (mon_bits[9] == ^e);
`endif
                  total++;
                  if (!ok) begin
                     bad++;
                     $display("FAIL frame got_bits=%b glitch=%0d exp_byte=%h", mon_bits, mon_glitch, e);
                  end
               end
            end
         end
      end
   end

   task automatic wait_done(input int limit, output time td, output bit ok);
      ok = 0;
      td = 0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clock);
         if (o_done === 1'b1) begin
            td = $time;
            ok = 1;
            return;
         end
      end
   endtask

   typedef struct {
      logic        mode;
      logic [7:0]  b;
      logic [31:0] w;
   } vec_t;

   vec_t vecs[6];

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog timeout total=%0d", total);
      $fatal(1, "watchdog");
   end

   initial begin : main
      time t0, td, td1, ts;
      bit  ok, idle_ok;
      int  d0, sc;

      vecs[0] = '{1'b0, 8'hAB, 32'h0000_0000};
      vecs[1] = '{1'b0, 8'h00, 32'hFFFF_FFFF};
      vecs[2] = '{1'b0, 8'hFF, 32'h0000_0000};
      vecs[3] = '{1'b0, 8'h01, 32'h1234_5678};
      vecs[4] = '{1'b1, 8'hEE, 32'h00FF_12CD};
      vecs[5] = '{1'b1, 8'h00, 32'hA55A_C33C};

      reset = 1'b1; enable = 1'b0; i_mode_select = 1'b0; i_word = '0; i_byte = '0;

      // Reset state, enable low.
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         chk("reset_idle", {30'd0, o_serial, o_done}, 32'd2);
      end
      @(posedge clock); #1 reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("idle_after_reset", {30'd0, o_serial, o_done}, 32'd2);
      end

      // Table-driven single transfers, enable dropped right after it is sampled.
      foreach (vecs[v]) begin
         @(posedge clock); #1;
         i_mode_select = vecs[v].mode;
         i_byte        = vecs[v].b;
         i_word        = vecs[v].w;
         if (vecs[v].mode) begin
            for (int k = 0; k < 4; k++) begin
               logic [31:0] wv;
               wv = vecs[v].w >> (8 * k);
               sb.push_back(wv[7:0]);
            end
         end else begin
            sb.push_back(vecs[v].b);
         end
         d0 = done_cnt;
         enable = 1'b1;
         @(posedge clock); t0 = $time; #1 enable = 1'b0;
         wait_done(400, td, ok);
         chk("done_seen", {31'd0, ok}, 32'd1);
         chk("done_latency", (td - t0 - 5) / 10, (vecs[v].mode ? 4 : 1) * FRAME_CYC);
         idle_ok = 1;
         for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (o_serial !== 1'b1) idle_ok = 0;
         end
         @(posedge clock);
         chk("single_done", done_cnt - d0, 1);
         chk("idle_line_after", {31'd0, idle_ok}, 32'd1);
         chk("sb_drained", sb.size(), 0);
      end

      // Enable held, i_byte changed mid-frame: current frame unaffected, next starts 2 cycles after o_done.
      @(posedge clock); #1;
      i_mode_select = 1'b0; i_byte = 8'hAB; sb.push_back(8'hAB);
      d0 = done_cnt;
      enable = 1'b1;
      @(posedge clock);
      repeat (15) @(posedge clock);
      #1 i_byte = 8'h10; sb.push_back(8'h10);
      wait_done(200, td1, ok);
      chk("hold_done1_seen", {31'd0, ok}, 32'd1);
      sc = start_cnt;
      ok = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clock);
         if (start_cnt != sc) begin ok = 1; break; end
      end
      ts = start_t;
      chk("hold_next_start_seen", {31'd0, ok}, 32'd1);
      chk("hold_gap_cycles", (ts - td1) / 10, 2);
      #1 enable = 1'b0;
      wait_done(200, td, ok);
      chk("hold_done2_seen", {31'd0, ok}, 32'd1);
      repeat (10) @(posedge clock);
      chk("hold_two_dones", done_cnt - d0, 2);
      chk("hold_sb_drained", sb.size(), 0);

      // Word transfer with enable dropped during the second byte.
      @(posedge clock); #1;
      i_mode_select = 1'b1; i_word = 32'h1122_3344;
      sb.push_back(8'h44); sb.push_back(8'h33); sb.push_back(8'h22); sb.push_back(8'h11);
      d0 = done_cnt;
      enable = 1'b1;
      @(posedge clock); t0 = $time;
      repeat (FRAME_CYC + 10) @(posedge clock);
      #1 enable = 1'b0;
      wait_done(400, td, ok);
      chk("word_drop_done_seen", {31'd0, ok}, 32'd1);
      chk("word_drop_latency", (td - t0 - 5) / 10, 4 * FRAME_CYC);
      idle_ok = 1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clock);
         if (o_serial !== 1'b1) idle_ok = 0;
      end
      @(posedge clock);
      chk("word_drop_idle", {31'd0, idle_ok}, 32'd1);
      chk("word_drop_single_done", done_cnt - d0, 1);
      chk("word_drop_sb_drained", sb.size(), 0);

      // Reset during a zero data bit: line returns high on the next edge, no o_done.
      @(posedge clock); #1;
      i_mode_select = 1'b0; i_byte = 8'h00;
      d0 = done_cnt;
      enable = 1'b1;
      @(posedge clock);
      repeat (13) @(posedge clock);
      #1 chk("pre_reset_data_low", {31'd0, o_serial}, 32'd0);
      reset = 1'b1; enable = 1'b0;
      @(posedge clock); #1;
      chk("reset_mid_serial", {31'd0, o_serial}, 32'd1);
      chk("reset_mid_done", {31'd0, o_done}, 32'd0);
      @(posedge clock); #1 reset = 1'b0;
      idle_ok = 1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clock);
         if (o_serial !== 1'b1 || o_done !== 1'b0) idle_ok = 0;
      end
      @(posedge clock);
      chk("reset_mid_idle", {31'd0, idle_ok}, 32'd1);
      chk("reset_mid_no_done", done_cnt - d0, 0);
      chk("reset_mid_sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
